frame_sync: RTL and testbench

FRAME_SYNC -- requirements
Module: frame_sync

---
 rtl/frame_sync.sv | 161 ++++++++++++++++
 tb/tb_frame_sync.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : frame_sync                                                |
// | Purpose  : Serial sync-word correlator with lock FSM and BPSK        |
// |            polarity resolution; emits polarity-corrected bytes.      |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module frame_sync #(
    parameter logic [15:0] SYNC_WORD     = 16'hEB90,
    parameter int          PAYLOAD_BYTES = 8,
    parameter int          MAX_ERR       = 1,
    parameter int          LOCK_CNT      = 2,
    parameter int          MISS_CNT      = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bitsync,
    input  logic       din,
    output logic [7:0] dout,
    output logic       dvalid,
    output logic       frame_start,
    output logic       locked,
    output logic       inverted
);

    localparam logic [1:0]  c_st_search        = 2'd0;
    localparam logic [1:0]  c_st_verify        = 2'd1;
    localparam logic [1:0]  c_st_lock          = 2'd2;
    localparam logic [10:0] c_last_payload_bit = 11'(PAYLOAD_BYTES * 8 - 1);
    localparam logic [10:0] c_last_window_bit  = 11'd15;
    localparam logic [4:0]  c_max_err          = 5'(MAX_ERR);
    localparam logic [7:0]  c_lock_cnt         = 8'(LOCK_CNT);
    localparam logic [7:0]  c_miss_cnt         = 8'(MISS_CNT);

    logic [1:0]  r_state;
    logic [15:0] r_shift;
    logic [7:0]  r_byte;
    logic [10:0] r_bit_cnt;
    logic        r_in_win;
    logic [7:0]  r_hit_cnt;
    logic [7:0]  r_miss_cnt;

    logic [15:0] w_shift;
    logic [7:0]  w_byte;
    logic [4:0]  w_dist_p;
    logic [4:0]  w_dist_n;
    logic        w_match_p;
    logic        w_match_n;
    logic        w_win_match;
    logic [7:0]  w_hit_next;
    logic [7:0]  w_miss_next;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) begin
            n = n + 5'(v[i]);
        end
        return n;
    endfunction

    // Correlation always uses the register contents including the bit arriving now.
    assign w_shift     = {r_shift[14:0], din};
    assign w_byte      = {r_byte[6:0], din};
    assign w_dist_p    = popcount16(w_shift ^ SYNC_WORD);
    assign w_dist_n    = popcount16(w_shift ^ ~SYNC_WORD);
    assign w_match_p   = (w_dist_p <= c_max_err);
    assign w_match_n   = (w_dist_n <= c_max_err);
    assign w_win_match = inverted ? w_match_n : w_match_p;
    assign w_hit_next  = r_hit_cnt + 8'd1;
    assign w_miss_next = r_miss_cnt + 8'd1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= c_st_search;
            r_shift     <= '0;
            r_byte      <= '0;
            r_bit_cnt   <= '0;
            r_in_win    <= 1'b0;
            r_hit_cnt   <= '0;
            r_miss_cnt  <= '0;
            dout        <= '0;
            dvalid      <= 1'b0;
            frame_start <= 1'b0;
            locked      <= 1'b0;
            inverted    <= 1'b0;
        end else begin
            dvalid      <= 1'b0;
            frame_start <= 1'b0;
            if (bitsync) begin
                r_shift <= w_shift;
                case (r_state)
                    c_st_search: begin
                        if (w_match_p || w_match_n) begin
                            inverted   <= ~w_match_p;
                            r_hit_cnt  <= 8'd1;
                            r_miss_cnt <= '0;
                            r_bit_cnt  <= '0;
                            r_in_win   <= 1'b0;
                            if (c_lock_cnt <= 8'd1) begin
                                r_state <= c_st_lock;
                                locked  <= 1'b1;
                            end else begin
                                r_state <= c_st_verify;
                            end
                        end
                    end
                    c_st_verify, c_st_lock: begin
                        if (!r_in_win) begin
                            r_byte <= w_byte;
                            if (r_bit_cnt[2:0] == 3'd7) begin
                                dout        <= w_byte ^ {8{inverted}};
                                dvalid      <= 1'b1;
                                frame_start <= (r_bit_cnt[10:3] == 8'd0);
                            end
                            if (r_bit_cnt == c_last_payload_bit) begin
                                r_bit_cnt <= '0;
                                r_in_win  <= 1'b1;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 11'd1;
                            end
                        end else if (r_bit_cnt != c_last_window_bit) begin
                            r_bit_cnt <= r_bit_cnt + 11'd1;
                        end else begin
                            r_bit_cnt <= '0;
                            r_in_win  <= 1'b0;
                            if (r_state == c_st_verify) begin
                                if (w_win_match) begin
                                    r_hit_cnt <= w_hit_next;
                                    if (w_hit_next >= c_lock_cnt) begin
                                        r_state <= c_st_lock;
                                        locked  <= 1'b1;
                                    end
                                end else begin
                                    r_state   <= c_st_search;
                                    r_hit_cnt <= '0;
                                end
                            end else if (w_win_match) begin
                                r_miss_cnt <= '0;
                            end else if (w_miss_next >= c_miss_cnt) begin
                                r_state    <= c_st_search;
                                locked     <= 1'b0;
                                r_hit_cnt  <= '0;
                                r_miss_cnt <= '0;
                            end else begin
                                // Flywheel: keep frame timing through a missed sync word.
                                r_miss_cnt <= w_miss_next;
                            end
                        end
                    end
                    default: begin
                        r_state <= c_st_search;
                        locked  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_frame_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_frame_sync                                             |
// | Purpose  : Directed self-checking bench for frame_sync.              |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_frame_sync;

    logic       clk     = 1'b0;
    logic       rst     = 1'b0;
    logic       bitsync = 1'b0;
    logic       din     = 1'b0;
    logic [7:0] dout;
    logic       dvalid;
    logic       frame_start;
    logic       locked;
    logic       inverted;

    int   checks = 0;
    int   errors = 0;
    logic inv_tx = 1'b0;
    logic [7:0] got_q[$];
    logic       fs_q[$];

    frame_sync dut (
        .clk         (clk),
        .rst         (rst),
        .bitsync     (bitsync),
        .din         (din),
        .dout        (dout),
        .dvalid      (dvalid),
        .frame_start (frame_start),
        .locked      (locked),
        .inverted    (inverted)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (dvalid) begin
            got_q.push_back(dout);
            fs_q.push_back(frame_start);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        bitsync = 1'b1;
        din     = b ^ inv_tx;
    endtask

    task automatic send_word(input logic [15:0] w);
        for (int i = 15; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic send_frame(input logic [7:0] first);
        for (int k = 0; k < 8; k++) send_byte(first + 8'(k));
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        bitsync = 1'b0;
        din     = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b0;
        bitsync = 1'b0;
        din     = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, " dout"},        32'(dout),        32'h00);
        check({tag, " dvalid"},      32'(dvalid),      32'h0);
        check({tag, " frame_start"}, 32'(frame_start), 32'h0);
        check({tag, " locked"},      32'(locked),      32'h0);
        check({tag, " inverted"},    32'(inverted),    32'h0);
    endtask

    task automatic clear_q();
        got_q.delete();
        fs_q.delete();
    endtask

    task automatic check_bytes(input string tag, input int n, input logic [7:0] first);
        check({tag, " count"}, 32'(got_q.size()), 32'(n));
        if (got_q.size() == n) begin
            for (int i = 0; i < n; i++) begin
                check($sformatf("%s byte%0d", tag, i), 32'(got_q[i]), 32'(first + 8'(i)));
                check($sformatf("%s fs%0d", tag, i), 32'(fs_q[i]), 32'((i % 8) == 0));
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b1;
        check_zero("reset");

        // Normal polarity acquisition and lock.
        clear_q();
        send_word(16'hEB90);
        idle(2);
        check("t1 verify locked", 32'(locked), 32'h0);
        check("t1 verify inverted", 32'(inverted), 32'h0);
        send_frame(8'h00);
        send_word(16'hEB90);
        idle(2);
        check("t1 lock locked", 32'(locked), 32'h1);
        send_frame(8'h08);
        idle(2);
        check_bytes("t1", 16, 8'h00);
        check("t1 inverted", 32'(inverted), 32'h0);
        check("t1 hold dvalid", 32'(dvalid), 32'h0);
        check("t1 hold dout", 32'(dout), 32'h0F);

        // Inverted polarity stream.
        do_reset();
        clear_q();
        inv_tx = 1'b1;
        send_word(16'hEB90);
        send_frame(8'h00);
        send_word(16'hEB90);
        send_frame(8'h08);
        inv_tx = 1'b0;
        idle(2);
        check("t2 inverted", 32'(inverted), 32'h1);
        check("t2 locked", 32'(locked), 32'h1);
        check_bytes("t2", 16, 8'h00);

        // Flywheel through one bad sync, drop on two consecutive.
        do_reset();
        clear_q();
        send_word(16'hEB90); send_frame(8'h00);
        send_word(16'hEB90); send_frame(8'h08);
        send_word(16'hEB9F); send_frame(8'h10);
        idle(2);
        check("t3 flywheel locked", 32'(locked), 32'h1);
        check("t3 flywheel count", 32'(got_q.size()), 32'd24);
        send_word(16'hEB90); send_frame(8'h18);
        send_word(16'hEB9F); send_frame(8'h20);
        send_word(16'hEB9F);
        idle(2);
        check("t3 drop locked", 32'(locked), 32'h0);
        check_bytes("t3", 40, 8'h00);
        for (int k = 0; k < 8; k++) send_byte(8'h00);
        idle(2);
        check("t3 search count", 32'(got_q.size()), 32'd40);
        check("t3 search locked", 32'(locked), 32'h0);

        // Tolerance: 1-bit errors accepted, 2-bit errors rejected.
        do_reset();
        clear_q();
        send_word(16'hEA90); send_frame(8'h00);
        send_word(16'hEB91); send_frame(8'h08);
        idle(2);
        check("t4 1err locked", 32'(locked), 32'h1);
        check_bytes("t4", 16, 8'h00);
        do_reset();
        clear_q();
        send_word(16'hEA91); send_frame(8'h00);
        send_word(16'h6B91); send_frame(8'h08);
        idle(2);
        check("t4 2err locked", 32'(locked), 32'h0);
        check("t4 2err count", 32'(got_q.size()), 32'd0);

        // Sync pattern inside locked payload must pass through.
        do_reset();
        clear_q();
        send_word(16'hEB90); send_frame(8'h00);
        send_word(16'hEB90);
        send_byte(8'hEB); send_byte(8'h90);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        send_byte(8'h44); send_byte(8'h55); send_byte(8'h66);
        send_word(16'hEB90); send_frame(8'h70);
        idle(2);
        check("t5 locked", 32'(locked), 32'h1);
        check("t5 count", 32'(got_q.size()), 32'd24);
        if (got_q.size() == 24) begin
            check("t5 byte8", 32'(got_q[8]), 32'hEB);
            check("t5 byte9", 32'(got_q[9]), 32'h90);
            check("t5 byte10", 32'(got_q[10]), 32'h11);
            check("t5 byte15", 32'(got_q[15]), 32'h66);
            check("t5 byte16", 32'(got_q[16]), 32'h70);
            check("t5 fs8", 32'(fs_q[8]), 32'h1);
            check("t5 fs9", 32'(fs_q[9]), 32'h0);
            check("t5 fs16", 32'(fs_q[16]), 32'h1);
        end

        // Reset mid-frame, then reacquire.
        do_reset();
        clear_q();
        send_word(16'hEB90);
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h02);
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
        idle(2);
        check("t6 pre count", 32'(got_q.size()), 32'd3);
        check("t6 pre dout", 32'(dout), 32'h02);
        do_reset();
        check_zero("t6 reset");
        clear_q();
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        send_byte(8'h04); send_byte(8'h05); send_byte(8'h06); send_byte(8'h07);
        idle(2);
        check("t6 post count", 32'(got_q.size()), 32'd0);
        check("t6 post locked", 32'(locked), 32'h0);
        send_word(16'hEB90); send_frame(8'h10);
        send_word(16'hEB90); send_frame(8'h18);
        idle(2);
        check("t6 relock", 32'(locked), 32'h1);
        check_bytes("t6", 16, 8'h10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
